// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Used by serial_adder and its full-adder cell.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit count needed to index 0..value-1; a WIDTH of 1 still gets a 1-bit counter.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, purely combinational.
// The serial adder reuses this one cell for every bit position.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on the accepting edge
// RUN     | one result bit per clock, WIDTH cycles
// DONE    | one-cycle done pulse, then back to IDLE
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CNT_W = clog2_min1(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic fa_s;
  logic fa_co;
  logic last_bit;
  logic accept;

  fa_cell u_fa_cell (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  assign accept   = (state_q == ST_IDLE) && start_i;
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_RUN:  busy_o = 1'b1;
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: load on accept, shift one bit per RUN cycle.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (accept) begin
      a_sh_d  = a_i;
      b_sh_d  = (sub_i == OP_SUB) ? ~b_i : b_i;
      carry_d = (sub_i == OP_ADD) ? cin_i : 1'b1;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_sh_d            = a_sh_q >> 1;
      b_sh_d            = b_sh_q >> 1;
      sum_d             = sum_q >> 1;
      sum_d[WIDTH-1]    = fa_s;
      carry_d           = fa_co;
      cnt_d             = cnt_q + CNT_W'(1);
      if (last_bit) begin
        cout_d = fa_co;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit carry_q is the carry into the MSB and fa_co the carry out of it.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) begin
      ovf_d = carry_q ^ fa_co;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  // Default build: no overflow output and no carry-history register.
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder at WIDTH=4; checks ovf_o too when
// SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_o;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_i = ~clk_i;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .sub_i   (sub_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts one operation at a negedge and returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic sub, input bit inject,
                        input logic [3:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
    int nbusy;
    int ndone;
    bit seen;
    nbusy = 0;
    seen  = 0;
    start_i = 1'b1;
    sub_i   = sub;
    a_i     = a;
    b_i     = b;
    cin_i   = cin;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1;
        break;
      end
      if (busy_o) nbusy++;
      // operands are don't-care after the accepting edge
      a_i   = ~a;
      b_i   = ~b;
      cin_i = ~cin;
      sub_i = ~sub;
      if (inject && i == 1) begin
        start_i = 1'b1;
        a_i     = 4'b0000;
        b_i     = 4'b0000;
        sub_i   = 1'b0;
        cin_i   = 1'b0;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    chk({tag, " busy_cycles"}, nbusy, 4);
    chk({tag, " done_seen"}, 32'(seen), 1);
    chk({tag, " busy_at_done"}, busy_o, 0);
    chk({tag, " sum"}, sum_o, exp_sum);
    chk({tag, " cout"}, cout_o, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " ovf"}, ovf_o, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("note: no ovf");
`endif
    @(negedge clk_i);
    chk({tag, " done_single"}, done_o, 0);
    if (inject) begin
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk_i);
        if (done_o) ndone++;
      end
      chk({tag, " extra_done"}, ndone, 0);
      chk({tag, " sum_hold"}, sum_o, exp_sum);
    end
  endtask

  initial begin
    int ndone;
    rst_i   = 1'b1;
    start_i = 1'b0;
    sub_i   = 1'b0;
    a_i     = '0;
    b_i     = '0;
    cin_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst sum", sum_o, 0);
    chk("rst cout", cout_o, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst ovf", ovf_o, 0);
`endif
    repeat (3) @(negedge clk_i);
    chk("idle busy", busy_o, 0);
    chk("idle done", done_o, 0);

    run_op("add7+5",    4'b0111, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1);
    run_op("addF+1+c",  4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0);
    run_op("sub3-5",    4'b0011, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0);
    run_op("sub8-1",    4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b1);
    run_op("add_inject", 4'b0111, 4'b0101, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b1);

    // Reset in the middle of a RUN
    start_i = 1'b1;
    sub_i   = 1'b0;
    a_i     = 4'b0111;
    b_i     = 4'b0101;
    cin_i   = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("midrst busy_before", busy_o, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst busy", busy_o, 0);
    chk("midrst done", done_o, 0);
    chk("midrst sum", sum_o, 0);
    chk("midrst cout", cout_o, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) ndone++;
    end
    chk("midrst no_activity", ndone, 0);

    run_op("add2+3", 4'b0010, 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
